// File: rtl/inst_fetch_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_if
// Instruction memory read port between the fetch stage and instruction memory.
//
// Transfer semantics: there is no ready/stall from memory. Whenever inst_ce is
// high, inst_addr is a valid word-aligned byte address and the memory returns
// the addressed word on inst_data combinationally in the same cycle. When
// inst_ce is low, inst_data is don't-care and is not consumed.
//
// Signals:
//   inst_ce   - read enable (fetch side -> memory)
//   inst_addr - byte address (fetch side -> memory)
//   inst_data - read word (memory -> fetch side)
// Modports:
//   master - fetch stage (drives ce/addr, samples data)
//   slave  - instruction memory (samples ce/addr, drives data)
// -----------------------------------------------------------------------------
interface inst_fetch_if;
  logic        inst_ce;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;

  modport master (
    output inst_ce,
    output inst_addr,
    input  inst_data
  );

  modport slave (
    input  inst_ce,
    input  inst_addr,
    output inst_data
  );
endinterface

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Fetch-side initiator for the instruction memory. Owns the PC, drives the
// memory read port and captures the returned word into the IF/ID register.
// Handles stall, ID-stage branch/jump redirect with one delay slot, exception
// flush and misaligned-fetch (AdEL) detection.
//
// Ports:
//   clk, rst_n        - clock (rising edge), asynchronous active-low reset
//   stall             - hold PC and IF/ID this cycle
//   flush, flush_pc   - exception/eret redirect, highest priority
//   branch_taken,
//   branch_target     - ID-stage taken branch/jump and its target
//   imem              - instruction memory port (inst_ce/inst_addr/inst_data)
//   id_pc, id_inst,
//   id_valid, id_adel - IF/ID pipeline register contents
//   dbg_state         - FSM state (0 = IDLE, 1 = RUN)
//   dbg_pend_valid    - a redirect taken during stall is waiting
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                flush,
  input  logic [31:0]         flush_pc,
  input  logic                branch_taken,
  input  logic [31:0]         branch_target,
  inst_fetch_if.master        imem,
  output logic [31:0]         id_pc,
  output logic [31:0]         id_inst,
  output logic                id_valid,
  output logic                id_adel,
  output logic                dbg_state,
  output logic                dbg_pend_valid
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;
  logic        id_adel_q, id_adel_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;

  logic        pc_aligned;

  assign pc_aligned = (pc_q[1:0] == 2'b00);

  // Misaligned PCs never touch memory; they still flow down the pipe as AdEL.
  assign imem.inst_ce   = (state_q == S_RUN) && pc_aligned;
  assign imem.inst_addr = pc_q;

  assign id_pc          = id_pc_q;
  assign id_inst        = id_inst_q;
  assign id_valid       = id_valid_q;
  assign id_adel        = id_adel_q;
  assign dbg_state      = (state_q == S_RUN);
  assign dbg_pend_valid = pend_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      id_pc_q       <= 32'h0;
      id_inst_q     <= NOP_WORD;
      id_valid_q    <= 1'b0;
      id_adel_q     <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_pc_q       <= id_pc_d;
      id_inst_q     <= id_inst_d;
      id_valid_q    <= id_valid_d;
      id_adel_q     <= id_adel_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_pc_d       = id_pc_q;
    id_inst_d     = id_inst_q;
    id_valid_d    = id_valid_q;
    id_adel_d     = id_adel_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;

    case (state_q)
      // The first edge out of reset only enables memory; pc stays at
      // RESET_PC so that address is the first one fetched.
      S_IDLE: state_d = S_RUN;

      S_RUN: begin
        if (flush) begin
          pc_d         = flush_pc;
          id_valid_d   = 1'b0;
          id_inst_d    = NOP_WORD;
          id_adel_d    = 1'b0;
          pend_valid_d = 1'b0;
        end else if (stall) begin
          // Remember a redirect resolved while frozen; the latest one wins.
          if (branch_taken) begin
            pend_valid_d  = 1'b1;
            pend_target_d = branch_target;
          end
        end else begin
          // The word fetched on a redirect edge is the delay slot: keep it.
          id_pc_d    = pc_q;
          id_inst_d  = pc_aligned ? imem.inst_data : NOP_WORD;
          id_valid_d = 1'b1;
          id_adel_d  = !pc_aligned;
          if (branch_taken) begin
            pc_d         = branch_target;
            pend_valid_d = 1'b0;
          end else if (pend_valid_q) begin
            pc_d         = pend_target_q;
            pend_valid_d = 1'b0;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
// Directed bench for inst_fetch. Each stimulus step pushes the expected
// post-edge view (memory port, IF/ID register, pending flag) into exp_q; a
// monitor on the falling edge pops and compares it.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

  localparam int W = 100;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        id_adel;
  logic        dbg_state;
  logic        dbg_pend_valid;

  int total;
  int bad;

  logic [W-1:0] exp_q[$];

  inst_fetch_if imem ();

  inst_fetch #(
    .RESET_PC (32'h0000_0000),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem           (imem.master),
    .id_pc          (id_pc),
    .id_inst        (id_inst),
    .id_valid       (id_valid),
    .id_adel        (id_adel),
    .dbg_state      (dbg_state),
    .dbg_pend_valid (dbg_pend_valid)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instruction memory model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0)      return 32'h0000_f025;
    else if (a == 32'h4) return 32'h241d_1000;
    else                 return {16'hc0de, a[15:0]};
  endfunction

  assign imem.inst_data = mem_word(imem.inst_addr);

  // Packed view: {ce, addr, valid, adel, id_pc, id_inst, pend}
  function automatic logic [W-1:0] pack(input logic ce, input logic [31:0] addr,
                                        input logic v, input logic adel,
                                        input logic [31:0] ipc, input logic [31:0] iinst,
                                        input logic pend);
    return {ce, addr, v, adel, ipc, iinst, pend};
  endfunction

  function automatic logic [W-1:0] observed();
    return pack(imem.inst_ce, imem.inst_addr, id_valid, id_adel, id_pc, id_inst,
                dbg_pend_valid);
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got ce=%b addr=%h v=%b adel=%b pc=%h inst=%h pend=%b, want ce=%b addr=%h v=%b adel=%b pc=%h inst=%h pend=%b",
               name, act[99], act[98:67], act[66], act[65], act[64:33], act[32:1], act[0],
               exp[99], exp[98:67], exp[66], exp[65], exp[64:33], exp[32:1], exp[0]);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  int edge_no;
  initial edge_no = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      edge_no++;
      check($sformatf("edge%0d", edge_no), observed(), e);
    end
  end

  // ---------------- driver ----------------
  // Called just after a falling edge: applies inputs for the next rising edge,
  // queues the expected state after that edge, and returns just after the
  // following falling edge.
  task automatic cyc(input logic st, input logic fl, input logic [31:0] fpc,
                     input logic br, input logic [31:0] bt,
                     input logic ece, input logic [31:0] eaddr, input logic ev,
                     input logic eadel, input logic [31:0] epc,
                     input logic [31:0] einst, input logic epend);
    stall         = st;
    flush         = fl;
    flush_pc      = fpc;
    branch_taken  = br;
    branch_target = bt;
    exp_q.push_back(pack(ece, eaddr, ev, eadel, epc, einst, epend));
    @(negedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    stall         = 1'b0;
    flush         = 1'b0;
    flush_pc      = 32'h0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;

    repeat (3) @(negedge clk);
    check("reset_vals", observed(), pack(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
    total++;
    if (dbg_state !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got %b want 0", dbg_state);
    end
    #1;
    rst_n = 1'b1;

    //   st  fl  fpc            br  bt             ce    addr           v     adel  id_pc          id_inst        pend
    // start-up: IDLE -> RUN, then two sequential fetches
    cyc(0, 0, 32'h0,         0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0);
    cyc(0, 0, 32'h0,         0, 32'h0,         1'b1, 32'h0000_0004, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_f025, 1'b0);
    cyc(0, 0, 32'h0,         0, 32'h0,         1'b1, 32'h0000_0008, 1'b1, 1'b0, 32'h0000_0004, 32'h241d_1000, 1'b0);
    // stall two cycles at pc=8
    cyc(1, 0, 32'h0,         0, 32'h0,         1'b1, 32'h0000_0008, 1'b1, 1'b0, 32'h0000_0004, 32'h241d_1000, 1'b0);
    cyc(1, 0, 32'h0,         0, 32'h0,         1'b1, 32'h0000_0008, 1'b1, 1'b0, 32'h0000_0004, 32'h241d_1000, 1'b0);
    cyc(0, 0, 32'h0,         0, 32'h0,         1'b1, 32'h0000_000c, 1'b1, 1'b0, 32'h0000_0008, 32'hc0de_0008, 1'b0);
    cyc(0, 0, 32'h0,         0, 32'h0,         1'b1, 32'h0000_0010, 1'b1, 1'b0, 32'h0000_000c, 32'hc0de_000c, 1'b0);
    // branch at pc=0x10 to 0x20: delay slot 0x10 captured
    cyc(0, 0, 32'h0,         1, 32'h0000_0020, 1'b1, 32'h0000_0020, 1'b1, 1'b0, 32'h0000_0010, 32'hc0de_0010, 1'b0);
    cyc(0, 0, 32'h0,         0, 32'h0,         1'b1, 32'h0000_0024, 1'b1, 1'b0, 32'h0000_0020, 32'hc0de_0020, 1'b0);
    // branch during stall; second branch overwrites the pending target
    cyc(1, 0, 32'h0,         1, 32'h0000_0200, 1'b1, 32'h0000_0024, 1'b1, 1'b0, 32'h0000_0020, 32'hc0de_0020, 1'b1);
    cyc(1, 0, 32'h0,         1, 32'h0000_0100, 1'b1, 32'h0000_0024, 1'b1, 1'b0, 32'h0000_0020, 32'hc0de_0020, 1'b1);
    cyc(0, 0, 32'h0,         0, 32'h0,         1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0024, 32'hc0de_0024, 1'b0);
    cyc(0, 0, 32'h0,         0, 32'h0,         1'b1, 32'h0000_0104, 1'b1, 1'b0, 32'h0000_0100, 32'hc0de_0100, 1'b0);
    // pending branch, then flush beats stall and branch and clears pending
    cyc(1, 0, 32'h0,         1, 32'h0000_0300, 1'b1, 32'h0000_0104, 1'b1, 1'b0, 32'h0000_0100, 32'hc0de_0100, 1'b1);
    cyc(1, 1, 32'h0000_0110, 1, 32'h0000_0300, 1'b1, 32'h0000_0110, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0000, 1'b0);
    cyc(0, 0, 32'h0,         0, 32'h0,         1'b1, 32'h0000_0114, 1'b1, 1'b0, 32'h0000_0110, 32'hc0de_0110, 1'b0);
    // misaligned branch target: no memory access, AdEL flows down
    cyc(0, 0, 32'h0,         1, 32'h0000_0022, 1'b0, 32'h0000_0022, 1'b1, 1'b0, 32'h0000_0114, 32'hc0de_0114, 1'b0);
    cyc(0, 0, 32'h0,         0, 32'h0,         1'b0, 32'h0000_0026, 1'b1, 1'b1, 32'h0000_0022, 32'h0000_0000, 1'b0);
    cyc(0, 0, 32'h0,         0, 32'h0,         1'b0, 32'h0000_002a, 1'b1, 1'b1, 32'h0000_0026, 32'h0000_0000, 1'b0);
    cyc(0, 1, 32'h0000_0040, 0, 32'h0,         1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0026, 32'h0000_0000, 1'b0);
    cyc(0, 0, 32'h0,         0, 32'h0,         1'b1, 32'h0000_0044, 1'b1, 1'b0, 32'h0000_0040, 32'hc0de_0040, 1'b0);
    // pc wrap from 0xFFFFFFFC to 0
    cyc(0, 1, 32'hffff_fffc, 0, 32'h0,         1'b1, 32'hffff_fffc, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0000, 1'b0);
    cyc(0, 0, 32'h0,         0, 32'h0,         1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'hffff_fffc, 32'hc0de_fffc, 1'b0);
    cyc(0, 0, 32'h0,         0, 32'h0,         1'b1, 32'h0000_0004, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_f025, 1'b0);
    // misaligned flush target, then async reset in mid-cycle
    cyc(0, 1, 32'h0000_0051, 0, 32'h0,         1'b0, 32'h0000_0051, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d entries left want 0", exp_q.size());
    end

    // Now 1 time unit after a falling edge; the next rising edge is 4 away.
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset", observed(), pack(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
    total++;
    if (dbg_state !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_state: got %b want 0", dbg_state);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Fetch-side initiator for the instruction memory read port (ce, addr → combinational data).
- Owns the PC and drives inst_ce/inst_addr.
- Captures the returned word into the IF/ID pipeline register.
- Handles pipeline stall, ID-stage branch/jump redirect (MIPS single delay slot), exception flush and misaligned-fetch detection.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word presented on bubbles and flushes.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  hold PC and IF/ID register this cycle.
- flush  input  1  exception/eret redirect, highest priority.
- flush_pc  input  32  redirect target when flush=1.
- branch_taken  input  1  ID-stage branch/jump resolved taken.
- branch_target  input  32  redirect target when branch_taken=1.
- inst_ce  output  1  instruction memory enable.
- inst_addr  output  32  byte address to instruction memory; equals pc.
- inst_data  input  32  word returned combinationally for inst_addr.
- id_pc  output  32  PC of the word in IF/ID.
- id_inst  output  32  instruction word in IF/ID.
- id_valid  output  1  IF/ID holds a real instruction.
- id_adel  output  1  IF/ID word came from a misaligned PC (AdEL on fetch).

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n). Async assertion clears all state immediately, including mid-operation.
- Reset values:
  - pc=RESET_PC, inst_ce=0, id_pc=0, id_inst=NOP_WORD, id_valid=0, id_adel=0.
  - pend_valid=0, pend_target=0.
- Two-state FSM, IDLE → RUN:
  - IDLE after reset. First rising edge with rst_n=1 moves to RUN and sets inst_ce=1.
  - pc does not advance on that edge. The first fetch address is RESET_PC.
  - RUN is held until reset.
- inst_addr = pc at all times. inst_ce = (state==RUN) && (pc[1:0]==0).
- Edge update in RUN, priority flush > stall > redirect > sequential:
  - flush: pc←flush_pc, id_valid←0, id_inst←NOP_WORD, id_adel←0, pend_valid←0. Flush during stall still applies.
  - stall (no flush): pc and IF/ID hold. If branch_taken=1, latch pend_target←branch_target and pend_valid←1. A second branch_taken during the same stall overwrites the pending target.
  - Redirect (no flush, no stall): capture IF/ID first (id_pc←pc, id_inst←fetched word, id_valid←1). Then:
    - branch_taken=1: pc←branch_target, clear pend.
    - else if pend_valid=1: pc←pend_target, pend_valid←0.
    - The word captured on a redirect edge is the delay-slot instruction and is kept.
  - Sequential: id_pc←pc, id_inst←(pc[1:0]==0 ? inst_data : NOP_WORD), id_valid←1, id_adel←(pc[1:0]!=0), pc←pc+4.
- Arithmetic: pc+4 is 32-bit modulo. 32'hFFFF_FFFC wraps to 0 with no flag.
- Misaligned PC:
  - Arises only via branch_target or flush_pc.
  - No memory access (inst_ce=0).
  - IF/ID gets id_adel=1, id_valid=1, id_inst=NOP_WORD.
  - pc keeps advancing until flush.
- Latency: inst_data for address A is visible on id_inst one edge after inst_addr=A.

Test Plan:
- Reset/start: hold rst_n=0 3 cycles, release; memory model returns 32'h0000f025 @0, 32'h241d1000 @4 → edge1 inst_ce=1/addr=0; edge2 id_pc=0, id_inst=0000f025, id_valid=1; edge3 id_pc=4, id_inst=241d1000.
- Stall: stall=1 for 2 cycles at pc=8 → inst_addr stays 8, id_* unchanged; after release id_pc=8 and pc=0xC.
- Branch with delay slot: branch_taken=1, target=0x20 while pc=0x10 → id_pc=0x10 is captured (delay slot), next inst_addr=0x20, then id_pc=0x20.
- Branch during stall: stall=1 with branch_taken=1, target=0x100, then stall=0 → pc stays until release; the release edge captures the delay slot and sets pc=0x100; pend_valid clears.
- Flush beats stall and branch: flush=1, flush_pc=0x110, stall=1, branch_taken=1 → pc=0x110, id_valid=0, pending cleared; next fetch from 0x110.
- Misalign and async reset: branch_target=0x22 → inst_ce=0, next edge id_adel=1, id_inst=0. Then assert rst_n=0 mid-cycle → outputs return to reset values without waiting for clk.
